data_memory_controller: RTL and testbench

//   Shares the single-port data memory between two requesters:

---
 rtl/data_memory_controller_pkg.sv | 11 +
 rtl/data_memory_controller_arbiter.sv | 30 +++
 rtl/data_memory_controller.sv | 98 +++++++++
 tb/tb_data_memory_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_controller_pkg.sv
// data_memory_controller_pkg: shared FSM state and port-select constants for the data memory controller
package data_memory_controller_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } state_t;
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;
endpackage

// File: rtl/data_memory_controller_arbiter.sv
// mem_rr_arbiter: two-way round-robin grant for the data memory controller
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_en               accept a grant this cycle (controller idle)
//   i_req_a, i_req_b   pending requests
//   o_valid            at least one request pending
//   o_grant            selected port (PORT_A / PORT_B)
module mem_rr_arbiter
    import data_memory_controller_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_valid,
    output logic o_grant
);
    logic last_grant;
    always_comb begin
        o_valid = i_req_a | i_req_b;
        // On contention the port that did not win last time gets the grant
        o_grant = (i_req_a && i_req_b) ? ~last_grant : (i_req_b ? PORT_B : PORT_A);
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_grant <= PORT_B;
        else if (i_en && o_valid)
            last_grant <= o_grant;
    end
endmodule

// File: rtl/data_memory_controller.sv
// data_memory_controller: shares a single-port data memory between the pipeline (A) and interrupt unit (B)
//   i_clk, i_rst_n             clock, asynchronous active-low reset
//   i_{a,b}_req/write/double   request, store flag, two-word access flag
//   i_{a,b}_address/wdata      word address, store data (single word uses low half)
//   o_{a,b}_ack/rdata          one-cycle completion pulse, load data (zero unless ack)
//   o_mem_*/i_mem_read_data    data memory interface (registered read, 1-cycle latency)
//   o_busy                     controller not idle
module data_memory_controller
    import data_memory_controller_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_a_req,
    input  logic                i_a_write,
    input  logic                i_a_double,
    input  logic [ADDR_W-1:0]   i_a_address,
    input  logic [2*DATA_W-1:0] i_a_wdata,
    output logic                o_a_ack,
    output logic [2*DATA_W-1:0] o_a_rdata,
    input  logic                i_b_req,
    input  logic                i_b_write,
    input  logic                i_b_double,
    input  logic [ADDR_W-1:0]   i_b_address,
    input  logic [2*DATA_W-1:0] i_b_wdata,
    output logic                o_b_ack,
    output logic [2*DATA_W-1:0] o_b_rdata,
    output logic [ADDR_W-1:0]   o_mem_address,
    output logic [DATA_W-1:0]   o_mem_write_data,
    output logic                o_mem_read,
    output logic                o_mem_write,
    input  logic [DATA_W-1:0]   i_mem_read_data,
    output logic                o_busy
);
    state_t                state, state_nx;
    logic                  idle, acc, done, win, grant, sel;
    logic                  wr_q, dbl_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [2*DATA_W-1:0]   wd_q, rdata;
    logic [DATA_W-1:0]     hi_q;

    mem_rr_arbiter u_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (idle),
        .i_req_a (i_a_req),
        .i_req_b (i_b_req),
        .o_valid (win),
        .o_grant (grant)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            sel    <= PORT_A;
            wr_q   <= 1'b0;
            dbl_q  <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
            hi_q   <= '0;
        end else begin
            state <= state_nx;
            if (idle && win) begin
                sel    <= grant;
                wr_q   <= (grant == PORT_B) ? i_b_write   : i_a_write;
                dbl_q  <= (grant == PORT_B) ? i_b_double  : i_a_double;
                addr_q <= (grant == PORT_B) ? i_b_address : i_a_address;
                wd_q   <= (grant == PORT_B) ? i_b_wdata   : i_a_wdata;
            end
            // Word0 of a double load arrives during ACC1 (registered memory read)
            if (state == ACC1 && !wr_q)
                hi_q <= i_mem_read_data;
        end
    end

    always_comb begin
        idle     = (state == IDLE);
        acc      = (state == ACC0) || (state == ACC1);
        done     = (state == DONE);
        state_nx = idle ? (win ? ACC0 : IDLE)
                 : (state == ACC0) ? (dbl_q ? ACC1 : DONE)
                 : (state == ACC1) ? DONE : IDLE;
        o_mem_address    = (state == ACC0) ? addr_q
                         : (state == ACC1) ? addr_q + 1'b1 : '0;
        o_mem_write_data = (state == ACC0) ? (dbl_q ? wd_q[2*DATA_W-1:DATA_W] : wd_q[DATA_W-1:0])
                         : (state == ACC1) ? wd_q[DATA_W-1:0] : '0;
        o_mem_read  = acc && !wr_q;
        o_mem_write = acc && wr_q;
        rdata = wr_q ? '0 : dbl_q ? {hi_q, i_mem_read_data} : {{DATA_W{1'b0}}, i_mem_read_data};
        o_a_ack   = done && (sel == PORT_A);
        o_b_ack   = done && (sel == PORT_B);
        o_a_rdata = o_a_ack ? rdata : '0;
        o_b_rdata = o_b_ack ? rdata : '0;
        o_busy    = !idle;
    end
endmodule

// File: tb/tb_data_memory_controller.sv
// tb_data_memory_controller: randomized and directed checks of the controller against a transaction-level model
module tb_data_memory_controller;
    typedef struct {
        bit          w;
        bit          d;
        logic [15:0] ad;
        logic [31:0] wd;
    } op_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_a_req = 0, i_a_write = 0, i_a_double = 0;
    logic [15:0] i_a_address = 0;
    logic [31:0] i_a_wdata = 0;
    logic        o_a_ack;
    logic [31:0] o_a_rdata;
    logic        i_b_req = 0, i_b_write = 0, i_b_double = 0;
    logic [15:0] i_b_address = 0;
    logic [31:0] i_b_wdata = 0;
    logic        o_b_ack;
    logic [31:0] o_b_rdata;
    logic [15:0] o_mem_address, o_mem_write_data, i_mem_read_data;
    logic        o_mem_read, o_mem_write, o_busy;

    logic [15:0] tb_mem [0:65535];
    logic [15:0] rmem   [0:65535];
    op_t         op [2];
    bit          last_g;
    int          total = 0;
    int          bad = 0;

    data_memory_controller dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_a_req(i_a_req), .i_a_write(i_a_write), .i_a_double(i_a_double),
        .i_a_address(i_a_address), .i_a_wdata(i_a_wdata), .o_a_ack(o_a_ack), .o_a_rdata(o_a_rdata),
        .i_b_req(i_b_req), .i_b_write(i_b_write), .i_b_double(i_b_double),
        .i_b_address(i_b_address), .i_b_wdata(i_b_wdata), .o_b_ack(o_b_ack), .o_b_rdata(o_b_rdata),
        .o_mem_address(o_mem_address), .o_mem_write_data(o_mem_write_data),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .i_mem_read_data(i_mem_read_data), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_mem_write)
            tb_mem[o_mem_address] <= o_mem_write_data;
        i_mem_read_data <= tb_mem[o_mem_address];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"}, o_busy, 0);
        check({tag, " a_ack"}, o_a_ack, 0);
        check({tag, " b_ack"}, o_b_ack, 0);
        check({tag, " a_rdata"}, o_a_rdata, 0);
        check({tag, " b_rdata"}, o_b_rdata, 0);
        check({tag, " mem_addr"}, o_mem_address, 0);
        check({tag, " mem_data"}, o_mem_write_data, 0);
        check({tag, " mem_rd"}, o_mem_read, 0);
        check({tag, " mem_wr"}, o_mem_write, 0);
    endtask

    task automatic model_apply(input op_t o, output logic [31:0] rd);
        logic [15:0] a1;
        a1 = o.ad + 16'd1;
        rd = 32'h0;
        if (o.w && o.d) begin
            rmem[o.ad] = o.wd[31:16];
            rmem[a1]   = o.wd[15:0];
        end else if (o.w)
            rmem[o.ad] = o.wd[15:0];
        else
            rd = o.d ? {rmem[o.ad], rmem[a1]} : {16'h0, rmem[o.ad]};
    endtask

    task automatic drive(input bit ra, input bit rb);
        i_a_req = ra; i_a_write = op[0].w; i_a_double = op[0].d; i_a_address = op[0].ad; i_a_wdata = op[0].wd;
        i_b_req = rb; i_b_write = op[1].w; i_b_double = op[1].d; i_b_address = op[1].ad; i_b_wdata = op[1].wd;
    endtask

    // One or two concurrent requests; the expected cycle-by-cycle behaviour follows from
    // the grant order and the per-transaction latency (2 or 3 cycles, one idle gap between).
    task automatic run(input bit ra, input bit rb);
        bit          two, p, ord0, ord1;
        int          d0, d1, s1, fin, s, st, dn, k;
        logic [31:0] e_rdata [2];
        logic        e_ack [2];
        logic [15:0] e_addr, e_data;
        logic        e_rd, e_wr;
        @(posedge i_clk);
        @(negedge i_clk);
        check("idle before req", o_busy, 0);
        two  = ra && rb;
        ord0 = two ? ~last_g : rb;
        ord1 = ~ord0;
        last_g = two ? ord1 : ord0;
        d0  = 1 + (op[ord0].d ? 2 : 1);
        s1  = d0 + 2;
        d1  = s1 + (op[ord1].d ? 2 : 1);
        fin = two ? d1 : d0;
        drive(ra, rb);
        for (int c = 1; c <= fin; c++) begin
            @(posedge i_clk);
            @(negedge i_clk);
            s = (c <= d0) ? 0 : (two && c >= s1) ? 1 : -1;
            p  = (s == 1) ? ord1 : ord0;
            st = (s == 1) ? s1 : 1;
            dn = (s == 1) ? d1 : d0;
            e_ack[0] = 0; e_ack[1] = 0; e_rdata[0] = 0; e_rdata[1] = 0;
            e_addr = 0; e_data = 0; e_rd = 0; e_wr = 0;
            if (s >= 0 && c == dn) begin
                e_ack[p] = 1;
                model_apply(op[p], e_rdata[p]);
            end else if (s >= 0) begin
                k = c - st;
                e_addr = op[p].ad + 16'(k);
                e_data = (k == 0 && op[p].d) ? op[p].wd[31:16] : op[p].wd[15:0];
                e_rd = !op[p].w;
                e_wr = op[p].w;
            end
            check("busy", o_busy, s >= 0 ? 1 : 0);
            check("a_ack", o_a_ack, e_ack[0]);
            check("b_ack", o_b_ack, e_ack[1]);
            check("a_rdata", o_a_rdata, e_rdata[0]);
            check("b_rdata", o_b_rdata, e_rdata[1]);
            check("mem_addr", o_mem_address, e_addr);
            check("mem_data", o_mem_write_data, e_data);
            check("mem_rd", o_mem_read, e_rd);
            check("mem_wr", o_mem_write, e_wr);
            if (e_ack[0]) i_a_req = 0;
            if (e_ack[1]) i_b_req = 0;
        end
    endtask

    task automatic set_op(input bit p, input bit w, input bit d, input logic [15:0] ad, input logic [31:0] wd);
        op[p].w = w; op[p].d = d; op[p].ad = ad; op[p].wd = wd;
    endtask

    task automatic do_reset();
        i_rst_n = 0;
        i_a_req = 0;
        i_b_req = 0;
        repeat (2) @(negedge i_clk);
        check_quiet("reset");
        i_rst_n = 1;
        last_g = 1;
    endtask

    initial begin
        logic [15:0] a;
        bit ra, rb;
        set_op(0, 0, 0, 0, 0);
        set_op(1, 0, 0, 0, 0);
        do_reset();
        set_op(0, 1, 0, 16'h0010, 32'h0000_0A00); run(1, 0);
        set_op(0, 0, 0, 16'h0010, 32'h0);         run(1, 0);
        set_op(1, 1, 1, 16'h0100, 32'h1234_5678); run(0, 1);
        set_op(1, 0, 1, 16'h0100, 32'h0);         run(0, 1);
        do_reset();
        set_op(0, 1, 0, 16'h0020, 32'h0000_1111);
        set_op(1, 1, 1, 16'h0030, 32'h2222_3333); run(1, 1);
        set_op(0, 0, 1, 16'h0030, 32'h0);
        set_op(1, 0, 0, 16'h0020, 32'h0);         run(1, 1);
        set_op(0, 1, 1, 16'hFFFF, 32'hCAFE_F00D); run(1, 0);
        set_op(0, 0, 1, 16'hFFFF, 32'h0);         run(1, 0);
        set_op(0, 1, 0, 16'h0201, 32'h0000_5555); run(1, 0);
        set_op(0, 1, 1, 16'h0200, 32'hDEAD_BEEF);
        @(posedge i_clk);
        @(negedge i_clk);
        drive(1, 0);
        @(posedge i_clk);
        @(negedge i_clk);
        check("rst acc0 wr", o_mem_write, 1);
        check("rst acc0 data", o_mem_write_data, 16'hDEAD);
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 0;
        i_a_req = 0;
        #1;
        check_quiet("mid reset");
        @(posedge i_clk);
        @(negedge i_clk);
        check_quiet("mid reset held");
        i_rst_n = 1;
        last_g = 1;
        rmem[16'h0200] = 16'hDEAD;
        set_op(0, 0, 1, 16'h0200, 32'h0);         run(1, 0);
        for (int i = 0; i < 17; i++) begin
            set_op(0, 1, 0, 16'hFFF8 + 16'(i), $urandom);
            run(1, 0);
        end
        for (int n = 0; n < 40; n++) begin
            ra = 1'($urandom_range(0, 1));
            rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int p = 0; p < 2; p++)
                set_op(1'(p), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       16'hFFF8 + 16'($urandom_range(0, 15)), $urandom);
            run(ra, rb);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        for (int i = 0; i < 17; i++) begin
            a = 16'hFFF8 + 16'(i);
            check("mem sweep", tb_mem[a], rmem[a]);
        end
        check("mem 0010", tb_mem[16'h0010], rmem[16'h0010]);
        check("mem 0100", tb_mem[16'h0100], rmem[16'h0100]);
        check("mem 0101", tb_mem[16'h0101], rmem[16'h0101]);
        check("mem 0200", tb_mem[16'h0200], rmem[16'h0200]);
        check("mem 0201", tb_mem[16'h0201], rmem[16'h0201]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
